// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and
// result-ready levels used by div_iter.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Bits needed by a counter that must hold 0..max_val inclusive.
    function automatic int cnt_bits(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             quot_bit
);

    // The remainder is always below the divisor, so {rem, bit} fits in WIDTH+1
    // bits and the extra top bit of the difference acts as the borrow flag.
    logic [WIDTH+1:0] trial;

    always_comb begin
        trial    = {rem, dividend_bit} - {2'b00, divisor};
        quot_bit = ~trial[WIDTH+1];
        rem_next = trial[WIDTH+1] ? {rem[WIDTH-1:0], dividend_bit} : trial[WIDTH:0];
    end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider retiring BPC quotient bits per cycle,
// with explicit divide-by-zero flag and pipeline annul.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_by_zero_o,
    output logic               stallreq_o
);

    localparam int CNT_W = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(BPC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - BPC);

    div_state_e         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH:0]     rem_reg, rem_next;
    logic [WIDTH-1:0]   dvd_reg, dvd_next;
    logic [WIDTH-1:0]   dvs_reg, dvs_next;
    logic               signed_reg, signed_next;
    logic               neg1_reg, neg1_next;
    logic               neg2_reg, neg2_next;
    logic [2*WIDTH-1:0] result_reg, result_next;
    logic               dbz_reg, dbz_next;
    logic               ready_reg, ready_next;

    logic [BPC:0][WIDTH:0] rem_chain;
    logic [BPC-1:0]        quot_bits;
    logic [WIDTH-1:0]      op1_mag, op2_mag;
    logic [WIDTH-1:0]      dvd_shift;
    logic [WIDTH-1:0]      quot_fin, rem_fin;

    assign rem_chain[0] = rem_reg;

    // The dividend register shifts out MSB-first while quotient bits shift in
    // at the bottom, so after WIDTH steps it holds the unsigned quotient.
    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_step
            div_step #(
                .WIDTH(WIDTH)
            ) u_step (
                .rem          (rem_chain[gi]),
                .dividend_bit (dvd_reg[WIDTH-1-gi]),
                .divisor      (dvs_reg),
                .rem_next     (rem_chain[gi+1]),
                .quot_bit     (quot_bits[BPC-1-gi])
            );
        end
    endgenerate

    always_comb begin
        op1_mag   = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        op2_mag   = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        dvd_shift = (dvd_reg << BPC) | WIDTH'(quot_bits);
        quot_fin  = (signed_reg && (neg1_reg ^ neg2_reg)) ? -dvd_shift : dvd_shift;
        rem_fin   = (signed_reg && neg1_reg) ? -rem_chain[BPC][WIDTH-1:0]
                                             :  rem_chain[BPC][WIDTH-1:0];
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        dvd_next    = dvd_reg;
        dvs_next    = dvs_reg;
        signed_next = signed_reg;
        neg1_next   = neg1_reg;
        neg2_next   = neg2_reg;
        result_next = result_reg;
        dbz_next    = dbz_reg;
        ready_next  = ready_reg;

        if (annul_i) begin
            state_next  = DivFree;
            result_next = '0;
            dbz_next    = 1'b0;
            ready_next  = DivResultNotReady;
        end else begin
            unique case (state_reg)
                DivFree: begin
                    if (start_i) begin
                        if (opdata2_i == '0) begin
                            state_next = DivByZero;
                        end else begin
                            state_next  = DivOn;
                            dvd_next    = op1_mag;
                            dvs_next    = op2_mag;
                            signed_next = signed_i;
                            neg1_next   = opdata1_i[WIDTH-1];
                            neg2_next   = opdata2_i[WIDTH-1];
                            rem_next    = '0;
                            cnt_next    = '0;
                        end
                    end
                end
                DivByZero: begin
                    state_next  = DivEnd;
                    result_next = '0;
                    dbz_next    = 1'b1;
                    ready_next  = DivResultReady;
                end
                DivOn: begin
                    rem_next = rem_chain[BPC];
                    dvd_next = dvd_shift;
                    cnt_next = cnt_reg + CNT_STEP;
                    if (cnt_reg == CNT_LAST) begin
                        state_next  = DivEnd;
                        result_next = {rem_fin, quot_fin};
                        ready_next  = DivResultReady;
                    end
                end
                DivEnd: begin
                    // Result stays put while the caller still holds start_i.
                    if (!start_i) begin
                        state_next  = DivFree;
                        result_next = '0;
                        dbz_next    = 1'b0;
                        ready_next  = DivResultNotReady;
                    end
                end
                default: begin
                    state_next = DivFree;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= DivFree;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            signed_reg <= 1'b0;
            neg1_reg   <= 1'b0;
            neg2_reg   <= 1'b0;
            result_reg <= '0;
            dbz_reg    <= 1'b0;
            ready_reg  <= DivResultNotReady;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            dvd_reg    <= dvd_next;
            dvs_reg    <= dvs_next;
            signed_reg <= signed_next;
            neg1_reg   <= neg1_next;
            neg2_reg   <= neg2_next;
            result_reg <= result_next;
            dbz_reg    <= dbz_next;
            ready_reg  <= ready_next;
        end
    end

    assign result_o      = result_reg;
    assign ready_o       = ready_reg;
    assign div_by_zero_o = dbz_reg;
    assign stallreq_o    = start_i & ~ready_reg & ~annul_i;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: three instances (32/1, 32/4, 16/2) driven by
// a directed table, hand-written annul/reset sequences and randomized operations.
`timescale 1ns/1ps
module tb_div_iter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start = '0;
    logic [2:0]  annul = '0;
    logic [2:0]  sgn   = '0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [15:0] a2 = '0, b2 = '0;
    logic [63:0] res0, res1;
    logic [31:0] res2;
    logic [2:0]  rdy, dbz, stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32), .BPC(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .annul_i(annul[0]), .signed_i(sgn[0]),
        .opdata1_i(a0), .opdata2_i(b0), .result_o(res0), .ready_o(rdy[0]),
        .div_by_zero_o(dbz[0]), .stallreq_o(stall[0])
    );
    div_iter #(.WIDTH(32), .BPC(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .annul_i(annul[1]), .signed_i(sgn[1]),
        .opdata1_i(a1), .opdata2_i(b1), .result_o(res1), .ready_o(rdy[1]),
        .div_by_zero_o(dbz[1]), .stallreq_o(stall[1])
    );
    div_iter #(.WIDTH(16), .BPC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start[2]), .annul_i(annul[2]), .signed_i(sgn[2]),
        .opdata1_i(a2), .opdata2_i(b2), .result_o(res2), .ready_o(rdy[2]),
        .div_by_zero_o(dbz[2]), .stallreq_o(stall[2])
    );

    typedef struct {
        int          sel;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          hold;
    } vec_t;

    vec_t vecs[10];

    function automatic int width_of(input int sel);
        return (sel == 2) ? 16 : 32;
    endfunction

    function automatic int n_of(input int sel);
        return (sel == 0) ? 32 : 8;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_ops(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0:       begin sgn[0] = s; a0 = a; b0 = b; end
            1:       begin sgn[1] = s; a1 = a; b1 = b; end
            default: begin sgn[2] = s; a2 = a[15:0]; b2 = b[15:0]; end
        endcase
    endtask

    task automatic get_out(input int sel, output logic [31:0] q, output logic [31:0] r,
                           output logic z, output logic rd);
        case (sel)
            0:       begin q = res0[31:0]; r = res0[63:32]; z = dbz[0]; rd = rdy[0]; end
            1:       begin q = res1[31:0]; r = res1[63:32]; z = dbz[1]; rd = rdy[1]; end
            default: begin q = {16'h0, res2[15:0]}; r = {16'h0, res2[31:16]}; z = dbz[2]; rd = rdy[2]; end
        endcase
    endtask

    // Reference: plain 64-bit arithmetic (truncating / and %), truncated to the width.
    task automatic model(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        logic [31:0]        mask, am, bm;
        logic signed [31:0] a32, b32;
        logic signed [15:0] a16, b16;
        longint             sa, sb, lq, lr;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        am = a & mask;
        bm = b & mask;
        a32 = am; b32 = bm; a16 = am[15:0]; b16 = bm[15:0];
        if (bm == 32'h0) begin
            q = '0; r = '0; z = 1'b1;
        end else begin
            if (s) begin
                sa = (w == 32) ? longint'(a32) : longint'(a16);
                sb = (w == 32) ? longint'(b32) : longint'(b16);
            end else begin
                sa = longint'(am);
                sb = longint'(bm);
            end
            lq = sa / sb;
            lr = sa % sb;
            q = 32'(lq) & mask;
            r = 32'(lr) & mask;
            z = 1'b0;
        end
    endtask

    task automatic do_op(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input int hold, input string tag);
        logic [31:0] gq, gr, hq, hr;
        logic        gz, rd, hz, hrd;
        int          edges, stalls, exp_lat;
        exp_lat = ez ? 2 : n_of(sel) + 1;
        set_ops(sel, s, a, b);
        start[sel] = 1'b1;
        edges = 0; stalls = 0; rd = 1'b0;
        gq = '0; gr = '0; gz = 1'b0;
        while (!rd && edges < 200) begin
            @(negedge clk);
            if (stall[sel]) stalls++;
            @(posedge clk);
            edges++;
            #1;
            // Latched operands only: scramble the inputs once the op is under way.
            if (edges == 1) set_ops(sel, ~s, $urandom, $urandom);
            get_out(sel, gq, gr, gz, rd);
        end
        check($sformatf("%s sel%0d latency", tag, sel), 64'(edges), 64'(exp_lat));
        check($sformatf("%s sel%0d stall cycles", tag, sel), 64'(stalls), 64'(exp_lat));
        check($sformatf("%s sel%0d quotient", tag, sel), {32'h0, gq}, {32'h0, eq});
        check($sformatf("%s sel%0d remainder", tag, sel), {32'h0, gr}, {32'h0, er});
        check($sformatf("%s sel%0d div_by_zero", tag, sel), {63'h0, gz}, {63'h0, ez});
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
                set_ops(sel, $urandom_range(0, 1) == 1, $urandom, $urandom);
            end
            get_out(sel, hq, hr, hz, hrd);
            check($sformatf("%s sel%0d held result", tag, sel), {hr, hq}, {er, eq});
            check($sformatf("%s sel%0d held ready", tag, sel), {63'h0, hrd}, 64'h1);
        end
        start[sel] = 1'b0;
        @(posedge clk);
        #1;
        get_out(sel, hq, hr, hz, hrd);
        check($sformatf("%s sel%0d ready cleared", tag, sel), {63'h0, hrd}, 64'h0);
        check($sformatf("%s sel%0d result cleared", tag, sel), {hr, hq}, 64'h0);
        $display("op %s sel=%0d s=%0b a=%h b=%h q=%h r=%h z=%0b lat=%0d", tag, sel, s, a, b, gq, gr, gz, edges);
    endtask

    initial begin
        logic [31:0] eq, er, ra, rb;
        logic        ez, rs, seen;
        int          rsel, wait_cnt;

        vecs[0] = '{0, 1'b0, 32'd100,       32'd7,       32'h0000_000E, 32'h0000_0002, 1'b0, 3};
        vecs[1] = '{0, 1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0};
        vecs[2] = '{0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,       1'b0, 0};
        vecs[3] = '{0, 1'b0, 32'd5,         32'd0,       32'h0,         32'h0,         1'b1, 2};
        vecs[4] = '{0, 1'b0, 32'd0,         32'd13,      32'h0,         32'h0,         1'b0, 0};
        vecs[5] = '{1, 1'b0, 32'hFFFF_FFFF, 32'h10,      32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 0};
        vecs[6] = '{2, 1'b0, 32'h0000_FFFF, 32'h10,      32'h0000_0FFF, 32'h0000_000F, 1'b0, 0};
        vecs[7] = '{2, 1'b1, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 32'h0,       1'b0, 0};
        vecs[8] = '{1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 0};
        vecs[9] = '{2, 1'b1, 32'h0000_FFF9, 32'd2,       32'h0000_FFFD, 32'h0000_FFFF, 1'b0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", {61'h0, rdy}, 64'h0);
        check("reset div_by_zero", {61'h0, dbz}, 64'h0);
        check("reset result0", res0, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].sel, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                  vecs[i].z, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Annul at iteration 10, then a fresh op with full latency
        set_ops(0, 1'b0, 32'd100, 32'd7);
        start[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul[0] = 1'b1;
        #1;
        check("annul stallreq", {63'h0, stall[0]}, 64'h0);
        @(posedge clk);
        #1;
        annul[0] = 1'b0;
        start[0] = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rdy[0]) seen = 1'b1;
        end
        check("annul ready never", {63'h0, seen}, 64'h0);
        do_op(0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0, "after-annul");

        // Annul together with start in FREE: stays FREE, next op has full latency
        set_ops(1, 1'b0, 32'd100, 32'd7);
        start[1] = 1'b1;
        annul[1] = 1'b1;
        #1;
        check("annul+start stallreq", {63'h0, stall[1]}, 64'h0);
        @(posedge clk);
        #1;
        annul[1] = 1'b0;
        do_op(1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, "annul+start");

        // Reset at iteration 5, then a full operation
        set_ops(0, 1'b0, 32'd1000, 32'd3);
        start[0] = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop reset ready", {61'h0, rdy}, 64'h0);
        check("midop reset result", res0, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start[0] = 1'b0;
        @(posedge clk);
        #1;
        do_op(0, 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 0, "after-reset");

        // Reset while a result is held in END clears it without a clock edge
        set_ops(2, 1'b1, 32'h0000_FFF9, 32'd2);
        start[2] = 1'b1;
        wait_cnt = 0;
        while (!rdy[2] && wait_cnt < 50) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        check("end-reset ready before", {63'h0, rdy[2]}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("end-reset ready async", {63'h0, rdy[2]}, 64'h0);
        check("end-reset result async", {32'h0, res2}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start[2] = 1'b0;
        @(posedge clk);
        #1;

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            rsel = $urandom_range(0, 2);
            rs = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0:       ra = 32'h0;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = 32'h8000_0000;
                3:       ra = 32'h0000_8000;
                default: ra = $urandom >> $urandom_range(0, 31);
            endcase
            case ($urandom_range(0, 9))
                0:       rb = 32'h0;
                1:       rb = 32'h1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'h0000_FFFF;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            model(width_of(rsel), rs, ra, rb, eq, er, ez);
            do_op(rsel, rs, ra, rb, eq, er, ez, 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
